// File: rtl/inv_arbiter.sv
// inv_arbiter: round-robin arbiter that feeds one shared W-bit inverter into a one-entry output register.
// Define INV_ARB_CNT_EN to add the 16-bit served_cnt port and its completed-result counter.
module inv_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*W-1:0]       req_data,
   output logic [NREQ-1:0]         req_ready,
   output logic                    out_valid,
   output logic [W-1:0]            out_data,
   output logic [$clog2(NREQ)-1:0] out_id,
   input  logic                    out_ready
`ifdef INV_ARB_CNT_EN
   ,
   output logic [15:0]             served_cnt
`endif
);
   localparam int IDW = $clog2(NREQ);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t         state_q, state_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0] out_id_q, out_id_d;
   logic [W-1:0]   out_data_q, out_data_d;

   logic [IDW-1:0] win;
   logic [IDW:0]   cand;
   logic           found;
   logic           can_load;
   logic           accept;
   logic           transfer;
   logic [W-1:0]   inv_in;
   logic [W-1:0]   inv_out;

   // Round-robin search: first valid index at or above rr_ptr, wrapping modulo NREQ.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NREQ)) begin
            cand = cand - (IDW+1)'(NREQ);
         end
         if (!found && req_valid[cand[IDW-1:0]]) begin
            found = 1'b1;
            win   = cand[IDW-1:0];
         end
      end
   end

   // The single inverter; only the winner's operand ever reaches it.
   assign inv_in  = req_data[int'(win)*W +: W];
   assign inv_out = ~inv_in;

   assign can_load = (state_q == EMPTY) || out_ready;
   assign accept   = found && can_load && !rst;
   assign transfer = (state_q == FULL) && out_ready;

   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[win] = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      out_data_d = out_data_q;
      out_id_d   = out_id_q;
      if (accept) begin
         state_d    = FULL;
         out_data_d = inv_out;
         out_id_d   = win;
         rr_ptr_d   = (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);
      end else if (transfer) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= EMPTY;
         rr_ptr_q   <= '0;
         out_data_q <= '0;
         out_id_q   <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         out_data_q <= out_data_d;
         out_id_q   <= out_id_d;
      end
   end

   assign out_valid = (state_q == FULL);
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;

`ifdef INV_ARB_CNT_EN
   logic [15:0] served_cnt_q, served_cnt_d;

   // Natural 16-bit wrap gives 0xFFFF -> 0x0000.
   always_comb begin
      served_cnt_d = served_cnt_q;
      if (transfer) begin
         served_cnt_d = served_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         served_cnt_q <= '0;
      end else begin
         served_cnt_q <= served_cnt_d;
      end
   end

   assign served_cnt = served_cnt_q;
`endif

endmodule

// File: tb/tb_inv_arbiter.sv
// Testbench for inv_arbiter: directed scenarios plus random traffic against a transaction-level model.
// With INV_ARB_CNT_EN defined it also checks served_cnt, including the 16-bit wrap.
module tb_inv_arbiter;
   localparam int NREQ = 4;
   localparam int W    = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ*W-1:0] req_data = '0;
   logic [NREQ-1:0]   req_ready;
   logic              out_valid;
   logic [W-1:0]      out_data;
   logic [IDW-1:0]    out_id;
   logic              out_ready = 1'b0;
`ifdef INV_ARB_CNT_EN
   logic [15:0]       served_cnt;
`endif

   int passed = 0;
   int total  = 0;

   // Reference model: the one held result, the round-robin start point and the transfer count.
   bit           m_valid = 1'b0;
   logic [W-1:0] m_data  = '0;
   int           m_id    = 0;
   int           m_ptr   = 0;
   int           m_cnt   = 0;

   inv_arbiter #(.NREQ(NREQ), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_id    (out_id),
      .out_ready (out_ready)
`ifdef INV_ARB_CNT_EN
      ,
      .served_cnt(served_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic int model_winner(input logic [NREQ-1:0] rv, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (rv[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   // One clock: drive, check req_ready before the edge, advance model, check outputs after it.
   task automatic cycle(input logic [NREQ-1:0] rv, input logic [NREQ*W-1:0] rd, input logic ordy);
      int              w;
      logic [NREQ-1:0] exp_rdy;
      req_valid = rv;
      req_data  = rd;
      out_ready = ordy;
      #1;
      w       = model_winner(rv, m_ptr);
      exp_rdy = '0;
      if (w >= 0 && (!m_valid || ordy)) exp_rdy[w] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      @(posedge clk);
      if (m_valid && ordy) m_cnt++;
      if (exp_rdy != '0) begin
         m_valid = 1'b1;
         m_data  = ~rd[w*W +: W];
         m_id    = w;
         m_ptr   = (w + 1) % NREQ;
      end else if (m_valid && ordy) begin
         m_valid = 1'b0;
      end
      #1;
      $display("cycle rv=%b rd=%h ordy=%0d -> out_valid=%0d out_id=%0d out_data=%h",
               rv, rd, ordy, out_valid, out_id, out_data);
      check("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
         check("out_data", 32'(out_data), 32'(m_data));
         check("out_id", 32'(out_id), 32'(m_id));
      end
`ifdef INV_ARB_CNT_EN
      check("served_cnt", 32'(served_cnt), 32'(m_cnt & 16'hFFFF));
`endif
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '1;
      req_data  = 16'($urandom);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_id", 32'(out_id), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
`ifdef INV_ARB_CNT_EN
      check("rst_served_cnt", 32'(served_cnt), 32'd0);
`endif
      rst       = 1'b0;
      req_valid = '0;
      m_valid   = 1'b0;
      m_data    = '0;
      m_id      = 0;
      m_ptr     = 0;
      m_cnt     = 0;
   endtask

   initial begin
      logic [W-1:0] exp029 [NREQ];
      int           prev_id;

      // Single request right after reset: 0x0 inverts to 0xF from requester 0.
      do_reset();
      cycle(4'b0001, 16'h0000, 1'b1);
      check("r028_valid", 32'(out_valid), 32'd1);
      check("r028_data", 32'(out_data), 32'hF);
      check("r028_id", 32'(out_id), 32'd0);

      // All four valid: results 0..3 back-to-back, then the pointer is back at 0.
      do_reset();
      exp029 = '{4'h5, 4'hA, 4'hC, 4'h3};
      for (int i = 0; i < NREQ; i++) begin
         cycle(4'b1111, 16'hC35A, 1'b1);
         check("r029_id", 32'(out_id), 32'(i));
         check("r029_data", 32'(out_data), 32'(exp029[i]));
      end
      req_valid = 4'b1111;
      #1;
      check("r029_ptr", 32'(req_ready), 32'b0001);
      cycle(4'b1111, 16'hC35A, 1'b1);

      // Backpressure: held 0x5 for 3 stalled cycles, then transfer and accept on one edge.
      do_reset();
      cycle(4'b0001, 16'h000A, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cycle(4'b0010, 16'h0070, 1'b0);
         check("r030_hold_data", 32'(out_data), 32'h5);
         check("r030_hold_ready", 32'(req_ready), 32'd0);
      end
      req_valid = 4'b0010;
      out_ready = 1'b1;
      #1;
      check("r030_accept_ready", 32'(req_ready), 32'b0010);
      cycle(4'b0010, 16'h0070, 1'b1);
      check("r030_new_data", 32'(out_data), 32'h8);
      check("r030_new_id", 32'(out_id), 32'd1);

      // Fairness between requesters 0 and 2.
      do_reset();
      prev_id = -1;
      for (int i = 0; i < 8; i++) begin
         cycle(4'b0101, 16'($urandom), 1'b1);
         check("r031_alt", 32'(out_id), (i % 2 == 0) ? 32'd0 : 32'd2);
         check("r031_norepeat", 32'(int'(out_id) == prev_id), 32'd0);
         prev_id = int'(out_id);
      end

      // Asynchronous reset while FULL, then requester 3 alone.
      cycle(4'b0001, 16'h0003, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("r032_async_drop", 32'(out_valid), 32'd0);
      do_reset();
      cycle(4'b1000, 16'h1000, 1'b1);
      check("r032_id", 32'(out_id), 32'd3);
      check("r032_data", 32'(out_data), 32'hE);

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         cycle(4'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0));
      end

`ifdef INV_ARB_CNT_EN
      // One accept edge plus 0x10005 transfer edges wraps the counter to 0x0005.
      do_reset();
      req_valid = 4'b0001;
      req_data  = 16'h0000;
      out_ready = 1'b1;
      repeat (32'h10006) @(posedge clk);
      #1;
      check("r033_served_cnt", 32'(served_cnt), 32'h0005);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
